rle_encoder: RTL and testbench

- Run-length encoder that sits directly downstream of the flip-flop delay chain and consumes its delayed output word stream.
- Collapses consecutive identical samples into (value, run length) records.
- Buffers records in a small FIFO and presents them on a valid/ready output for a logger or bus bridge.

---
 rtl/rle_pkg.sv | 19 +
 rtl/rle_fifo.sv | 64 ++++++
 rtl/rle_encoder.sv | 138 +++++++++++++
 tb/tb_rle_encoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared types for the run-length encoder: FSM state, record layout,
// default field widths and the drop counter width.
package rle_pkg;

    localparam int REC_DW     = 8;
    localparam int REC_CNT_W  = 8;
    localparam int DROP_CNT_W = 16;

    typedef enum logic {
        IDLE,
        RUN
    } rle_state_t;

    typedef struct packed {
        logic [REC_DW-1:0]    data;
        logic [REC_CNT_W-1:0] run;
    } rle_rec_t;

endpackage

// File: rtl/rle_fifo.sv
// First-word-fall-through record FIFO for the run-length encoder.
// Ports: clk, rst (async, active-high), push/din/full, pop/dout/empty.
// A push while full is accepted only if a pop happens on the same edge.
// dout keeps the last popped record while the FIFO is empty.
module rle_fifo
    import rle_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  rle_rec_t din,
    output logic     full,
    input  logic     pop,
    output rle_rec_t dout,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    rle_rec_t          mem [DEPTH];
    rle_rec_t          last;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? last : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last   <= mem[rd_ptr];
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder: folds repeated samples into (value, run) records
// queued in a FWFT FIFO behind a valid/ready output.
// Ports: clk, rst (async, active-high), in_data/in_en, flush,
// out_valid/out_ready/out_data/out_run, ovf (sticky drop flag).
// Build option RLE_DROP_CNT_EN adds drop_cnt, a saturating count of
// records dropped on a full FIFO.
module rle_encoder
    import rle_pkg::*;
#(
    parameter int DW         = REC_DW,
    parameter int CNT_W      = REC_CNT_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DW-1:0]         in_data,
    input  logic                  in_en,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic [CNT_W-1:0]      out_run,
`ifdef RLE_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
    output logic                  ovf
);

    localparam logic [CNT_W-1:0] RUN_MAX = '1;

    rle_state_t        state;
    rle_state_t        state_n;
    logic [DW-1:0]     cur_val;
    logic [DW-1:0]     val_n;
    logic [CNT_W-1:0]  run;
    logic [CNT_W-1:0]  run_n;
    logic              emit;
    logic              full;
    logic              empty;
    logic              drop;
    rle_rec_t          push_rec;
    rle_rec_t          pop_rec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cur_val <= '0;
            run     <= '0;
        end else begin
            state   <= state_n;
            cur_val <= val_n;
            run     <= run_n;
        end
    end

    always_comb begin
        state_n = state;
        val_n   = cur_val;
        run_n   = run;
        emit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_en) begin
                    val_n   = in_data;
                    run_n   = CNT_W'(1);
                    state_n = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    emit = 1'b1;
                    if (in_en) begin
                        val_n = in_data;
                        run_n = CNT_W'(1);
                    end else begin
                        run_n   = '0;
                        state_n = IDLE;
                    end
                end else if (in_en) begin
                    if (in_data != cur_val) begin
                        emit  = 1'b1;
                        val_n = in_data;
                        run_n = CNT_W'(1);
                    end else if (run != RUN_MAX) begin
                        run_n = run + CNT_W'(1);
                    end else begin
                        // Saturated run closes; this sample opens the next.
                        emit  = 1'b1;
                        run_n = CNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign push_rec.data = REC_DW'(cur_val);
    assign push_rec.run  = REC_CNT_W'(run);

    rle_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (emit),
        .din  (push_rec),
        .full (full),
        .pop  (out_ready),
        .dout (pop_rec),
        .empty(empty)
    );

    assign out_valid = !empty;
    assign out_data  = DW'(pop_rec.data);
    assign out_run   = CNT_W'(pop_rec.run);

    // A full FIFO only has room if the consumer pops on this same edge.
    assign drop = emit && full && !out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end

`ifdef RLE_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rle_encoder.sv
// Directed self-checking bench for rle_encoder with default parameters.
// Expected records are hand-computed from the stimulus sequences.
module tb_rle_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_en = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [7:0]  out_run;
    logic        ovf;
`ifdef RLE_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    rle_encoder #(
        .DW(8),
        .CNT_W(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_en    (in_en),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_run  (out_run),
`ifdef RLE_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_en = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic feed(input logic [7:0] v, input int n);
        in_en = 1'b1;
        in_data = v;
        for (int i = 0; i < n; i++) step();
        in_en = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic pop_exp(input string tag, input logic [7:0] d,
                           input logic [7:0] r);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"}, 32'(out_data), 32'(d));
        check({tag, ".run"}, 32'(out_run), 32'(r));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data", 32'(out_data), 32'd0);
        check("rst.run", 32'(out_run), 32'd0);
        check("rst.ovf", 32'(ovf), 32'd0);

        // Basic run closed by a new value.
        feed(8'h0F, 5);
        check("t1.pre", 32'(out_valid), 32'd0);
        feed(8'h0A, 1);
        pop_exp("t1.rec", 8'h0F, 8'd5);
        check("t1.empty", 32'(out_valid), 32'd0);
        check("t1.hold", 32'(out_data), 32'h0F);
        do_flush();
        pop_exp("t1.tail", 8'h0A, 8'd1);

        // Mixed runs, closing flush, then IDLE ignores a lone flush.
        do_reset();
        feed(8'h0A, 2);
        feed(8'h0B, 5);
        feed(8'h0C, 1);
        feed(8'h0D, 3);
        do_flush();
        pop_exp("t2.a", 8'h0A, 8'd2);
        pop_exp("t2.b", 8'h0B, 8'd5);
        pop_exp("t2.c", 8'h0C, 8'd1);
        pop_exp("t2.d", 8'h0D, 8'd3);
        do_flush();
        check("t2.idle", 32'(out_valid), 32'd0);

        // Saturation at 255.
        feed(8'h0F, 300);
        do_flush();
        pop_exp("t3.max", 8'h0F, 8'd255);
        pop_exp("t3.rest", 8'h0F, 8'd45);
        check("t3.ovf", 32'(ovf), 32'd0);

        // Overflow with a stalled consumer.
        do_reset();
        for (int i = 0; i < 7; i++) feed((i % 2 == 0) ? 8'h01 : 8'h02, 1);
        check("t4.ovf", 32'(ovf), 32'd1);
`ifdef RLE_DROP_CNT_EN
        check("t4.drops", 32'(drop_cnt), 32'd2);
`endif
        pop_exp("t4.r0", 8'h01, 8'd1);
        pop_exp("t4.r1", 8'h02, 8'd1);
        pop_exp("t4.r2", 8'h01, 8'd1);
        pop_exp("t4.r3", 8'h02, 8'd1);
        check("t4.drained", 32'(out_valid), 32'd0);
        do_flush();
        pop_exp("t4.open", 8'h01, 8'd1);
        check("t4.sticky", 32'(ovf), 32'd1);

        // Push into a full FIFO while popping; flush with a new sample.
        do_reset();
        for (int i = 1; i <= 5; i++) feed(8'(i), 1);
        check("t5.full", 32'(out_data), 32'h01);
        in_en = 1'b1;
        in_data = 8'h06;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_en = 1'b0;
        check("t5.ovf", 32'(ovf), 32'd0);
`ifdef RLE_DROP_CNT_EN
        check("t5.drops", 32'(drop_cnt), 32'd0);
`endif
        pop_exp("t5.r2", 8'h02, 8'd1);
        pop_exp("t5.r3", 8'h03, 8'd1);
        pop_exp("t5.r4", 8'h04, 8'd1);
        pop_exp("t5.r5", 8'h05, 8'd1);
        feed(8'h06, 1);
        in_en = 1'b1;
        in_data = 8'h07;
        do_flush();
        in_en = 1'b0;
        pop_exp("t5.old", 8'h06, 8'd2);
        do_flush();
        pop_exp("t5.new", 8'h07, 8'd1);

        // Asynchronous reset in the middle of a run.
        do_reset();
        feed(8'h09, 1);
        feed(8'h05, 3);
        check("t6.queued", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6.async", 32'(out_valid), 32'd0);
        check("t6.run0", 32'(out_run), 32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        check("t6.norec", 32'(out_valid), 32'd0);
        feed(8'h05, 1);
        do_flush();
        pop_exp("t6.fresh", 8'h05, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
